sync_fifo_fwft: RTL and testbench

Single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides. It wraps the team's `DP_RAM` storage and adds pointer, occupancy and prefetch logic. The block hides the RAM's one-cycle read latency so the consumer sees head data whenever `M_VALID` is high. It sits in each router input port between the link receiver and the route-compute/arbiter stage.

---
 rtl/sync_fifo_fwft_pkg.sv | 7 +
 rtl/DP_RAM.sv | 37 +++
 rtl/sync_fifo_fwft.sv | 79 +++++++
 tb/tb_sync_fifo_fwft.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_fwft_pkg.sv
// Shared defaults for the first-word-fall-through FIFO and its storage.
package sync_fifo_fwft_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/DP_RAM.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents and read data clear on a synchronous active-low reset.
module DP_RAM
  import sync_fifo_fwft_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              WR_CLK,
  input  logic              RD_CLK,
  input  logic              RSTn,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]  WR_DATA,
  input  logic              RD_EN,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [WIDTH-1:0]  RD_DATA
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge WR_CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (WR_EN) begin
      mem[WR_ADDR] <= WR_DATA;
    end
  end

  // Read data holds between read enables; the FIFO relies on that as its output stage.
  always_ff @(posedge RD_CLK) begin
    if (!RSTn)      RD_DATA <= '0;
    else if (RD_EN) RD_DATA <= mem[RD_ADDR];
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FWFT FIFO around DP_RAM: pointer/occupancy tracking plus a
// prefetch into the RAM read register so the head is visible whenever M_VALID is high.
module sync_fifo_fwft
  import sync_fifo_fwft_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 2)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] S_DATA,
  input  logic             S_VALID,
  output logic             S_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [CNT_W-1:0] COUNT
);

  localparam int               PTR_W    = ADDR_W + 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] ram_cnt;
  logic             out_valid;
  logic             wr_en;
  logic             rd_issue;
  logic [WIDTH-1:0] rd_data;

  assign ram_cnt  = wr_ptr - rd_ptr;
  assign S_READY  = !RST && (ram_cnt != FULL_CNT);
  assign wr_en    = S_VALID && S_READY;
  // Refill the output stage whenever it is empty or being drained this cycle.
  assign rd_issue = (ram_cnt != '0) && (!out_valid || M_READY);

  assign M_VALID  = out_valid;
  assign M_DATA   = out_valid ? rd_data : '0;
  assign COUNT    = CNT_W'(ram_cnt) + CNT_W'(out_valid);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_issue) rd_ptr <= rd_ptr + PTR_W'(1);
      if (rd_issue)                    out_valid <= 1'b1;
      else if (out_valid && M_READY)   out_valid <= 1'b0;
    end
  end

  DP_RAM #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .WR_CLK  (CLK),
    .RD_CLK  (CLK),
    .RSTn    (~RST),
    .WR_EN   (wr_en),
    .WR_ADDR (wr_ptr[ADDR_W-1:0]),
    .WR_DATA (S_DATA),
    .RD_EN   (rd_issue),
    .RD_ADDR (rd_ptr[ADDR_W-1:0]),
    .RD_DATA (rd_data)
  );

  a_no_overflow : assert property (@(posedge CLK) disable iff (RST)
    !(wr_en && (ram_cnt == FULL_CNT)));
  a_no_underflow : assert property (@(posedge CLK) disable iff (RST)
    !(rd_issue && (ram_cnt == '0)));
  a_count_range : assert property (@(posedge CLK) disable iff (RST)
    COUNT <= MAX_CNT);

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_sync_fifo_fwft;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 2);

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] S_DATA;
  logic             S_VALID;
  logic             S_READY;
  logic [WIDTH-1:0] M_DATA;
  logic             M_VALID;
  logic             M_READY;
  logic [CNT_W-1:0] COUNT;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 0;

  // Reference model: entries sitting in RAM, plus one visible head entry.
  logic [WIDTH-1:0] ram_q [$];
  logic [WIDTH-1:0] sb    [$];
  logic [WIDTH-1:0] out_data = '0;
  bit               has_out  = 0;

  sync_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .S_DATA  (S_DATA),
    .S_VALID (S_VALID),
    .S_READY (S_READY),
    .M_DATA  (M_DATA),
    .M_VALID (M_VALID),
    .M_READY (M_READY),
    .COUNT   (COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Inputs change just after posedge, so at negedge they are what the next edge samples.
  always @(negedge CLK) begin : model
    bit               exp_sready;
    bit               pop;
    logic [WIDTH-1:0] sb_head;
    exp_sready = !RST && (ram_q.size() != DEPTH);
    if (chk_en) begin
      check("s_ready", 32'(S_READY), 32'(exp_sready));
      check("m_valid", 32'(M_VALID), 32'(has_out));
      check("m_data",  32'(M_DATA),  has_out ? 32'(out_data) : 32'd0);
      check("count",   32'(COUNT),   32'(ram_q.size()) + 32'(has_out));
    end
    if (RST) begin
      ram_q.delete();
      sb.delete();
      has_out = 0;
    end else begin
      pop = has_out && M_READY;
      if (pop && sb.size() > 0) begin
        sb_head = sb.pop_front();
        if (chk_en) check("pop_order", 32'(M_DATA), 32'(sb_head));
      end
      if (ram_q.size() != 0 && (!has_out || M_READY)) begin
        out_data = ram_q.pop_front();
        has_out  = 1;
      end else if (pop) begin
        has_out = 0;
      end
      if (S_VALID && exp_sready) begin
        ram_q.push_back(S_DATA);
        sb.push_back(S_DATA);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    RST     = 1'b1;
    S_VALID = 1'b0;
    M_READY = 1'b0;
    repeat (n) tick();
    RST = 1'b0;
  endtask

  task automatic fill17();
    M_READY = 1'b0;
    for (int i = 0; i < 17; i++) begin
      S_VALID = 1'b1;
      S_DATA  = 8'(i);
      tick();
    end
    S_VALID = 1'b0;
  endtask

  initial begin
    RST     = 1'b1;
    S_VALID = 1'b0;
    S_DATA  = '0;
    M_READY = 1'b0;

    // Reset state
    do_reset(2);
    chk_en = 1;
    @(negedge CLK);
    check("rst_s_ready", 32'(S_READY), 32'd1);
    check("rst_count",   32'(COUNT),   32'd0);
    check("rst_m_data",  32'(M_DATA),  32'd0);

    // Fall-through: write at cycle 0, visible at cycle 2
    tick();
    S_VALID = 1'b1;
    S_DATA  = 8'hA5;
    tick();
    S_VALID = 1'b0;
    @(negedge CLK);
    check("ft_c1_count",  32'(COUNT),   32'd1);
    check("ft_c1_mvalid", 32'(M_VALID), 32'd0);
    tick();
    @(negedge CLK);
    check("ft_c2_mvalid", 32'(M_VALID), 32'd1);
    check("ft_c2_mdata",  32'(M_DATA),  32'hA5);
    check("ft_c2_count",  32'(COUNT),   32'd1);
    M_READY = 1'b1;
    repeat (3) tick();

    // Fill to DEPTH+1, then a refused write, then drain in order
    do_reset(1);
    fill17();
    S_VALID = 1'b1;
    S_DATA  = 8'h11;
    @(negedge CLK);
    check("fill_s_ready", 32'(S_READY), 32'd0);
    check("fill_count",   32'(COUNT),   32'd17);
    tick();
    S_VALID = 1'b0;
    M_READY = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      check("drain_mvalid", 32'(M_VALID), 32'd1);
      check("drain_mdata",  32'(M_DATA),  32'(i));
      tick();
    end
    @(negedge CLK);
    check("drain_end_mvalid", 32'(M_VALID), 32'd0);
    check("drain_end_count",  32'(COUNT),   32'd0);

    // Full boundary: pop and write in the same cycle at COUNT = 17
    fill17();
    S_VALID = 1'b1;
    S_DATA  = 8'h77;
    M_READY = 1'b1;
    @(negedge CLK);
    check("fb_c0_s_ready", 32'(S_READY), 32'd0);
    check("fb_c0_count",   32'(COUNT),   32'd17);
    tick();
    M_READY = 1'b0;
    @(negedge CLK);
    check("fb_c1_s_ready", 32'(S_READY), 32'd1);
    check("fb_c1_count",   32'(COUNT),   32'd16);
    tick();
    S_VALID = 1'b0;
    @(negedge CLK);
    check("fb_c2_count", 32'(COUNT), 32'd17);
    M_READY = 1'b1;
    repeat (20) tick();

    // Streaming: no bubbles after the two-cycle fill
    do_reset(1);
    S_VALID = 1'b1;
    M_READY = 1'b1;
    for (int i = 0; i < 100; i++) begin
      S_DATA = 8'(i);
      @(negedge CLK);
      if (i >= 2) begin
        check("stream_mvalid", 32'(M_VALID), 32'd1);
        check("stream_mdata",  32'(M_DATA),  32'(8'(i - 2)));
      end
      tick();
    end
    S_VALID = 1'b0;
    repeat (4) tick();

    // Random backpressure against the model
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      S_VALID = 1'($urandom_range(0, 1));
      S_DATA  = 8'($urandom);
      M_READY = 1'($urandom_range(0, 1));
      tick();
    end
    S_VALID = 1'b0;
    M_READY = 1'b1;
    repeat (20) tick();

    // Reset mid-burst at COUNT = 9
    do_reset(1);
    M_READY = 1'b0;
    for (int i = 0; i < 9; i++) begin
      S_VALID = 1'b1;
      S_DATA  = 8'(8'h40 + i);
      tick();
    end
    S_DATA  = 8'h50;
    M_READY = 1'b1;
    @(negedge CLK);
    check("mid_count_before", 32'(COUNT), 32'd9);
    tick();
    RST = 1'b1;
    tick();
    RST     = 1'b0;
    S_VALID = 1'b1;
    S_DATA  = 8'h3C;
    M_READY = 1'b0;
    @(negedge CLK);
    check("mid_rst_mvalid",  32'(M_VALID), 32'd0);
    check("mid_rst_count",   32'(COUNT),   32'd0);
    check("mid_rst_s_ready", 32'(S_READY), 32'd1);
    tick();
    S_VALID = 1'b0;
    @(negedge CLK);
    check("mid_c1_count",  32'(COUNT),   32'd1);
    check("mid_c1_mvalid", 32'(M_VALID), 32'd0);
    tick();
    @(negedge CLK);
    check("mid_c2_mvalid", 32'(M_VALID), 32'd1);
    check("mid_c2_mdata",  32'(M_DATA),  32'h3C);
    M_READY = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
